// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: widths, MDU latency
// default and the E-stage forwarding select encoding.
package hazard_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W  = 5;
  localparam int unsigned DEF_MDU_LATENCY = 32;
  localparam int unsigned MDU_CNT_W       = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_mdu_busy_counter.sv
// Countdown tracker for the multi-cycle multiply/divide unit; busy while the
// count is non-zero, new starts are ignored until it reaches zero.
module mdu_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = DEF_MDU_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  logic [MDU_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start && (cnt == '0)) begin
      cnt <= MDU_CNT_W'(MDU_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - MDU_CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: stall/flush generation,
// E- and D-stage forwarding selects, and MDU busy tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int unsigned MDU_LATENCY = DEF_MDU_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  input  logic                  reg_write_e,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_to_reg_m,
  input  logic                  branch_d,
  input  logic                  pc_redirect_d,
  input  logic                  mdu_op_d,
  input  logic                  mfhilo_d,
  input  logic                  mdu_start_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  forward_a_d,
  output logic                  forward_b_d,
  output logic                  mdu_busy
);

  // $zero is hardwired, so it never creates a dependency.
  function automatic logic hit(input logic [REG_ADDR_W-1:0] dst,
                               input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  fwd_sel_e sel_a_e;
  fwd_sel_e sel_b_e;
  logic     load_use_stall;
  logic     branch_stall;
  logic     mdu_stall;
  logic     stall;

  mdu_busy_counter #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_busy_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mdu_start_e),
    .busy (mdu_busy)
  );

  always_comb begin
    sel_a_e = FWD_NONE;
    sel_b_e = FWD_NONE;
    if (reg_write_m && hit(write_reg_m, rs_e))      sel_a_e = FWD_MEM;
    else if (reg_write_w && hit(write_reg_w, rs_e)) sel_a_e = FWD_WB;
    if (reg_write_m && hit(write_reg_m, rt_e))      sel_b_e = FWD_MEM;
    else if (reg_write_w && hit(write_reg_w, rt_e)) sel_b_e = FWD_WB;
  end

  always_comb begin
    load_use_stall = mem_to_reg_e &&
                     (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
    branch_stall   = branch_d &&
                     ((reg_write_e  && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
                      (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
    mdu_stall      = mdu_busy && (mfhilo_d || mdu_op_d);
    stall          = load_use_stall || branch_stall || mdu_stall;
  end

  assign forward_a_e = sel_a_e;
  assign forward_b_e = sel_b_e;
  assign forward_a_d = reg_write_m && hit(write_reg_m, rs_d);
  assign forward_b_d = reg_write_m && hit(write_reg_m, rt_d);

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  // A stalled redirect is held in D and retires once its operands are ready.
  assign flush_d = pc_redirect_d && !stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, a reset-mid-op sequence and
// random stimulus compared against a cycle-indexed reference model.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, m2r_e, m2r_m;
    logic       br, redir, mdu_op, mfhilo, start;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       flush_d;
    logic [1:0] fa_e, fb_e;
    logic       fa_d, fb_d;
    logic       busy;
  } out_t;

  typedef struct packed {
    in_t  v;
    out_t e;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, pc_redirect_d, mdu_op_d, mfhilo_d, mdu_start_e;
  logic       stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d, mdu_busy;
  logic [1:0] forward_a_e, forward_b_e;

  int errors = 0;
  int checks = 0;
  int t = 0;         // rising edges applied since time zero
  int busy_end = 0;  // first cycle index at which the MDU is free again
  rec_t tbl[$];

  hazard_ctrl #(
    .REG_ADDR_W (5),
    .MDU_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (write_reg_e),
    .write_reg_m  (write_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_e  (reg_write_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e),
    .mem_to_reg_m (mem_to_reg_m),
    .branch_d     (branch_d),
    .pc_redirect_d(pc_redirect_d),
    .mdu_op_d     (mdu_op_d),
    .mfhilo_d     (mfhilo_d),
    .mdu_start_e  (mdu_start_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .forward_a_d  (forward_a_d),
    .forward_b_d  (forward_b_d),
    .mdu_busy     (mdu_busy)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic out_t mk(input logic s, input logic fd, input logic [1:0] fae,
                              input logic [1:0] fbe, input logic fad, input logic fbd,
                              input logic b);
    out_t o;
    o.stall = s; o.flush_d = fd; o.fa_e = fae; o.fb_e = fbe;
    o.fa_d = fad; o.fb_d = fbd; o.busy = b;
    return o;
  endfunction

  function automatic bit dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  // Reference: rules applied directly, MDU busy from the cycle-index window.
  function automatic out_t model(input in_t v, input bit busy);
    out_t o;
    bit lu, bs, ms;
    o = '0;
    o.busy = busy;
    o.fa_e = (v.rw_m && dep(v.wr_m, v.rs_e)) ? 2'd2 : (v.rw_w && dep(v.wr_w, v.rs_e)) ? 2'd1 : 2'd0;
    o.fb_e = (v.rw_m && dep(v.wr_m, v.rt_e)) ? 2'd2 : (v.rw_w && dep(v.wr_w, v.rt_e)) ? 2'd1 : 2'd0;
    o.fa_d = v.rw_m && dep(v.wr_m, v.rs_d);
    o.fb_d = v.rw_m && dep(v.wr_m, v.rt_d);
    lu = v.m2r_e && (dep(v.wr_e, v.rs_d) || dep(v.wr_e, v.rt_d));
    bs = v.br && ((v.rw_e && (dep(v.wr_e, v.rs_d) || dep(v.wr_e, v.rt_d))) ||
                  (v.m2r_m && (dep(v.wr_m, v.rs_d) || dep(v.wr_m, v.rt_d))));
    ms = busy && (v.mfhilo || v.mdu_op);
    o.stall = lu || bs || ms;
    o.flush_d = v.redir && !o.stall;
    return o;
  endfunction

  task automatic drive(input in_t v);
    rst_n = v.rst_n; rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    write_reg_e = v.wr_e; write_reg_m = v.wr_m; write_reg_w = v.wr_w;
    reg_write_e = v.rw_e; reg_write_m = v.rw_m; reg_write_w = v.rw_w;
    mem_to_reg_e = v.m2r_e; mem_to_reg_m = v.m2r_m; branch_d = v.br;
    pc_redirect_d = v.redir; mdu_op_d = v.mdu_op; mfhilo_d = v.mfhilo; mdu_start_e = v.start;
  endtask

  // One cycle: drive at negedge, compare 1 time unit later, then take the edge.
  task automatic step(input in_t v, input bit use_tbl, input out_t e,
                      input string name, input int idx);
    out_t exp_o;
    logic [10:0] act, req;
    @(negedge clk);
    drive(v);
    #1;
    if (!v.rst_n) busy_end = t;
    exp_o = use_tbl ? e : model(v, t < busy_end);
    act = {stall_f, stall_d, flush_e, flush_d, forward_a_e, forward_b_e,
           forward_a_d, forward_b_d, mdu_busy};
    req = {exp_o.stall, exp_o.stall, exp_o.stall, exp_o.flush_d, exp_o.fa_e, exp_o.fb_e,
           exp_o.fa_d, exp_o.fb_d, exp_o.busy};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] got=%b required=%b (sf sd fe fd fae fbe fad fbd busy)",
               name, idx, act, req);
    end
    @(posedge clk);
    if (v.rst_n && v.start && !(t < busy_end)) busy_end = t + 1 + int'(LAT);
    t++;
  endtask

  task automatic add(input in_t v, input out_t e);
    rec_t r;
    r.v = v; r.e = e;
    tbl.push_back(r);
  endtask

  initial begin
    in_t v;
    drive(idle());
    rst_n = 1'b0;

    // reset state with idle inputs
    v = idle(); v.rst_n = 1'b0;                                  add(v, mk(0,0,0,0,0,0,0));
    v = idle();                                                  add(v, mk(0,0,0,0,0,0,0));
    // load-use on rs, then load moves to M
    v = idle(); v.rs_d=8; v.m2r_e=1; v.rw_e=1; v.wr_e=8;         add(v, mk(1,0,0,0,0,0,0));
    v = idle(); v.rs_d=8; v.m2r_m=1; v.rw_m=1; v.wr_m=8;         add(v, mk(0,0,0,0,1,0,0));
    v = idle(); v.rt_d=9; v.m2r_e=1; v.rw_e=1; v.wr_e=9;         add(v, mk(1,0,0,0,0,0,0));
    v = idle(); v.m2r_e=1; v.rw_e=1;                             add(v, mk(0,0,0,0,0,0,0));
    // E forwarding: M beats W, W alone, $zero never forwards
    v = idle(); v.rw_m=1; v.wr_m=9; v.rw_w=1; v.wr_w=9; v.rs_e=9; v.rt_e=9;
                                                                 add(v, mk(0,0,2,2,0,0,0));
    v = idle(); v.wr_m=9; v.rw_w=1; v.wr_w=9; v.rs_e=9; v.rt_e=9; add(v, mk(0,0,1,1,0,0,0));
    v = idle(); v.rw_w=1; v.wr_w=9; v.rt_e=9;                    add(v, mk(0,0,0,1,0,0,0));
    v = idle(); v.rw_m=1; v.rw_w=1;                              add(v, mk(0,0,0,0,0,0,0));
    // branch on ALU result in E, then resolved with forward from M
    v = idle(); v.br=1; v.redir=1; v.rs_d=10; v.rw_e=1; v.wr_e=10; add(v, mk(1,0,0,0,0,0,0));
    v = idle(); v.br=1; v.redir=1; v.rs_d=10; v.rw_m=1; v.wr_m=10; add(v, mk(0,1,0,0,1,0,0));
    v = idle(); v.br=1; v.rt_d=11; v.m2r_m=1; v.rw_m=1; v.wr_m=11; add(v, mk(1,0,0,0,0,1,0));
    v = idle(); v.rs_d=12; v.rw_e=1; v.wr_e=12;                  add(v, mk(0,0,0,0,0,0,0));
    // redirect held by load-use, released next cycle
    v = idle(); v.redir=1; v.rs_d=8; v.m2r_e=1; v.rw_e=1; v.wr_e=8; add(v, mk(1,0,0,0,0,0,0));
    v = idle(); v.redir=1; v.rs_d=8; v.m2r_m=1; v.rw_m=1; v.wr_m=8; add(v, mk(0,1,0,0,1,0,0));
    // MDU op, then MFHI held for exactly LAT cycles
    v = idle(); v.start=1;                                       add(v, mk(0,0,0,0,0,0,0));
    for (int unsigned i = 0; i < LAT; i++) begin
      v = idle(); v.mfhilo=1;                                    add(v, mk(1,0,0,0,0,0,1));
    end
    v = idle(); v.mfhilo=1;                                      add(v, mk(0,0,0,0,0,0,0));
    // second MDU op; start while busy ignored; load-use overlaps MDU stall
    v = idle(); v.start=1; v.mdu_op=1;                           add(v, mk(0,0,0,0,0,0,0));
    v = idle(); v.start=1; v.mdu_op=1; v.rs_d=5; v.m2r_e=1; v.wr_e=5;
                                                                 add(v, mk(1,0,0,0,0,0,1));
    for (int unsigned i = 1; i < LAT; i++) begin
      v = idle(); v.mdu_op=1;                                    add(v, mk(1,0,0,0,0,0,1));
    end
    v = idle(); v.mdu_op=1;                                      add(v, mk(0,0,0,0,0,0,0));
    // reset two cycles into an op
    v = idle(); v.start=1;                                       add(v, mk(0,0,0,0,0,0,0));
    v = idle(); v.mfhilo=1;                                      add(v, mk(1,0,0,0,0,0,1));
    v = idle(); v.mfhilo=1;                                      add(v, mk(1,0,0,0,0,0,1));
    v = idle(); v.mfhilo=1; v.rst_n=0;                           add(v, mk(0,0,0,0,0,0,0));
    v = idle(); v.mfhilo=1;                                      add(v, mk(0,0,0,0,0,0,0));
    v = idle(); v.mfhilo=1;                                      add(v, mk(0,0,0,0,0,0,0));

    foreach (tbl[i]) step(tbl[i].v, 1'b1, tbl[i].e, "vec", i);

    for (int i = 0; i < 400; i++) begin
      v = idle();
      v.rst_n  = ($urandom_range(0, 63) != 0);
      v.rs_d   = 5'($urandom_range(0, 3)); v.rt_d = 5'($urandom_range(0, 3));
      v.rs_e   = 5'($urandom_range(0, 3)); v.rt_e = 5'($urandom_range(0, 3));
      v.wr_e   = 5'($urandom_range(0, 3)); v.wr_m = 5'($urandom_range(0, 3));
      v.wr_w   = 5'($urandom_range(0, 3));
      v.rw_e   = 1'($urandom); v.rw_m = 1'($urandom); v.rw_w = 1'($urandom);
      v.m2r_e  = 1'($urandom); v.m2r_m = 1'($urandom);
      v.br     = 1'($urandom); v.redir = 1'($urandom);
      v.mdu_op = ($urandom_range(0, 3) == 0); v.mfhilo = ($urandom_range(0, 3) == 0);
      v.start  = ($urandom_range(0, 5) == 0);
      step(v, 1'b0, '0, "rand", i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
